proc_run_ctrl: RTL and testbench

PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

---
 rtl/proc_run_pkg.sv | 15 +
 rtl/sat_counter.sv | 25 ++
 rtl/proc_run_ctrl.sv | 126 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_run_pkg.sv
// Shared state encoding and default sizing for the processor reset-then-run controller.
package proc_run_pkg;

  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_RST_CYCLES = 2;
  localparam int unsigned DEF_RUN_CYCLES = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority) and enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX_VAL)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Holds the cores in reset for a fixed time, releases them for a measured run window,
// and counts run cycles and per-core zero-flag cycles.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned RUN_CYCLES = DEF_RUN_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         run_len,
  input  logic [NUM_CH-1:0]        zero_in,
  output logic                     core_reset,
  output logic                     core_run,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [NUM_CH*CNT_W-1:0]  zero_count,
  output logic [NUM_CH-1:0]        zero_seen
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_DEF  = CNT_W'(RUN_CYCLES);

  state_e              state_q;
  logic [CNT_W-1:0]    timer_q;
  logic [CNT_W-1:0]    len_q;
  logic                core_reset_q;
  logic                core_run_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_CH-1:0]   zero_seen_q;

  logic                accept;
  logic                in_run;
  logic                cnt_clr;
  logic [CNT_W-1:0]    eff_len;

  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_run  = (state_q == ST_RUN);
  assign cnt_clr = reset || accept;
  assign eff_len = (run_len == '0) ? RUN_DEF : run_len;

  // Sequencer: timer_q counts clocks within the current RST or RUN phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      len_q        <= '0;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      zero_seen_q  <= '0;
    end else begin
      if (in_run) begin
        zero_seen_q <= zero_seen_q | zero_in;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_RST;
            timer_q      <= '0;
            len_q        <= eff_len;
            zero_seen_q  <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        ST_RST: begin
          if (timer_q == RST_LAST) begin
            state_q      <= ST_RUN;
            timer_q      <= '0;
            core_reset_q <= 1'b0;
            core_run_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (timer_q == (len_q - CNT_W'(1))) begin
            state_q      <= ST_DONE;
            timer_q      <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clock),
    .clr_i (cnt_clr),
    .en_i  (in_run),
    .q_o   (cycle_count)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_zero
    sat_counter #(.W(CNT_W)) u_zero_cnt (
      .clk_i (clock),
      .clr_i (cnt_clr),
      .en_i  (in_run && zero_in[i]),
      .q_o   (zero_count[i*CNT_W +: CNT_W])
    );
  end

  assign core_reset = core_reset_q;
  assign core_run   = core_run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign zero_seen  = zero_seen_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: a 4-channel default-width instance and a 1-channel
// 3-bit-counter instance share stimulus; expected results come from a sequence-level model.
module tb_proc_run_ctrl;

  localparam int R = 2;

  typedef struct packed {
    int          done_edge;
    int          run_first;
    int          run_cnt;
    int          cyc;
    logic [63:0] zc;
    logic [3:0]  zs;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] run_len;
  logic [3:0]  zero_in;

  logic        core_reset_a, core_run_a, busy_a, done_a;
  logic [15:0] cycle_count_a;
  logic [63:0] zero_count_a;
  logic [3:0]  zero_seen_a;

  logic        core_reset_b, core_run_b, busy_b, done_b;
  logic [2:0]  cycle_count_b;
  logic [2:0]  zero_count_b;
  logic [0:0]  zero_seen_b;

  int   edge_no = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  logic [3:0] zpat [0:31];

  proc_run_ctrl #(.NUM_CH(4)) u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .run_len     (run_len),
    .zero_in     (zero_in),
    .core_reset  (core_reset_a),
    .core_run    (core_run_a),
    .busy        (busy_a),
    .done        (done_a),
    .cycle_count (cycle_count_a),
    .zero_count  (zero_count_a),
    .zero_seen   (zero_seen_a)
  );

  proc_run_ctrl #(.NUM_CH(1), .CNT_W(3), .RST_CYCLES(2), .RUN_CYCLES(7)) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .run_len     (run_len[2:0]),
    .zero_in     (zero_in[0:0]),
    .core_reset  (core_reset_b),
    .core_run    (core_run_b),
    .busy        (busy_b),
    .done        (done_b),
    .cycle_count (cycle_count_b),
    .zero_count  (zero_count_b),
    .zero_seen   (zero_seen_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_no <= edge_no + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome of one sequence: zero counts are the zero_in bits seen during the L run cycles.
  function automatic exp_t model(input int n, input int l, input int nch, input int maxv);
    exp_t e;
    int   s;
    e.done_edge = n + R + l;
    e.run_first = n + R;
    e.run_cnt   = l;
    e.cyc       = l;
    e.zc        = '0;
    e.zs        = '0;
    for (int ch = 0; ch < nch; ch++) begin
      s = 0;
      for (int j = R + 1; j <= R + l; j++) s += int'(zpat[j][ch]);
      e.zs[ch] = (s > 0);
      if (s > maxv) s = maxv;
      e.zc[ch*16 +: 16] = 16'(s);
    end
    return e;
  endfunction

  task automatic check_item(input string tag, input exp_t e, input int ed, input int first,
                            input int cnt, input logic [63:0] cyc, input logic [63:0] zc,
                            input logic [63:0] zs, input logic bsy);
    chk({tag, "_done_edge"}, 64'(ed), 64'(e.done_edge));
    chk({tag, "_run_first_edge"}, 64'(first), 64'(e.run_first));
    chk({tag, "_run_cycles"}, 64'(cnt), 64'(e.run_cnt));
    chk({tag, "_cycle_count"}, cyc, 64'(e.cyc));
    chk({tag, "_zero_count"}, zc, e.zc);
    chk({tag, "_zero_seen"}, zs, 64'(e.zs));
    chk({tag, "_busy_in_done"}, 64'(bsy), 64'(0));
  endtask

  // Monitor A
  initial begin
    int   first, cnt;
    logic prev_run, prev_done;
    exp_t e;
    first = 0; cnt = 0; prev_run = 1'b0; prev_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (core_run_a && !prev_run) begin first = edge_no; cnt = 0; end
      if (core_run_a) cnt++;
      chk("a_core_reset_vs_run", 64'(core_reset_a), 64'(!core_run_a));
      if (done_a && !prev_done) begin
        if (exp_a.size() == 0) chk("a_unexpected_done", 64'(1), 64'(0));
        else begin
          e = exp_a.pop_front();
          check_item("a", e, edge_no, first, cnt, 64'(cycle_count_a), zero_count_a,
                     64'(zero_seen_a), busy_a);
        end
      end
      prev_run  = core_run_a;
      prev_done = done_a;
    end
  end

  // Monitor B
  initial begin
    int   first, cnt;
    logic prev_run, prev_done;
    exp_t e;
    first = 0; cnt = 0; prev_run = 1'b0; prev_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (core_run_b && !prev_run) begin first = edge_no; cnt = 0; end
      if (core_run_b) cnt++;
      chk("b_core_reset_vs_run", 64'(core_reset_b), 64'(!core_run_b));
      if (done_b && !prev_done) begin
        if (exp_b.size() == 0) chk("b_unexpected_done", 64'(1), 64'(0));
        else begin
          e = exp_b.pop_front();
          e.zc = 64'(e.zc[2:0]);
          e.zs = 4'(e.zs[0]);
          check_item("b", e, edge_no, first, cnt, 64'(cycle_count_b), 64'(zero_count_b),
                     64'(zero_seen_b), busy_b);
        end
      end
      prev_run  = core_run_b;
      prev_done = done_b;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_a_core_reset"}, 64'(core_reset_a), 64'(1));
    chk({tag, "_a_core_run"}, 64'(core_run_a), 64'(0));
    chk({tag, "_a_busy"}, 64'(busy_a), 64'(0));
    chk({tag, "_a_done"}, 64'(done_a), 64'(0));
    chk({tag, "_a_cycle_count"}, 64'(cycle_count_a), 64'(0));
    chk({tag, "_a_zero_count"}, zero_count_a, 64'(0));
    chk({tag, "_a_zero_seen"}, 64'(zero_seen_a), 64'(0));
    chk({tag, "_b_busy"}, 64'(busy_b), 64'(0));
    chk({tag, "_b_done"}, 64'(done_b), 64'(0));
    chk({tag, "_b_cycle_count"}, 64'(cycle_count_b), 64'(0));
    chk({tag, "_b_zero_count"}, 64'(zero_count_b), 64'(0));
  endtask

  // Called just after a falling edge; start is sampled at the next rising edge.
  task automatic run_seq(input logic [15:0] rl, input bit hold, input logic [3:0] zc, input bit mid);
    int   la, lb, n, span, midj;
    logic [2:0] rlb;
    rlb  = rl[2:0];
    la   = (rl == 16'd0) ? 7 : int'(rl);
    lb   = (rlb == 3'd0) ? 7 : int'(rlb);
    span = R + ((la > lb) ? la : lb) + 1;
    for (int j = 0; j <= span; j++) zpat[j] = hold ? zc : 4'($urandom);
    n = edge_no + 1;
    exp_a.push_back(model(n, la, 4, 65535));
    exp_b.push_back(model(n, lb, 1, 7));
    midj = mid ? int'($urandom_range(R + ((la < lb) ? la : lb), 1)) : 0;
    start   = 1'b1;
    run_len = rl;
    zero_in = 4'($urandom);
    @(negedge clock);
    start = 1'b0;
    chk("start_clears_a_cycle", 64'(cycle_count_a), 64'(0));
    chk("start_clears_a_zero", zero_count_a, 64'(0));
    chk("start_clears_a_seen", 64'(zero_seen_a), 64'(0));
    chk("start_clears_b_zero", 64'(zero_count_b), 64'(0));
    chk("start_a_busy", 64'(busy_a), 64'(1));
    for (int j = 1; j <= span; j++) begin
      zero_in = zpat[j];
      start   = (j == midj);
      if (j == midj) run_len = 16'($urandom_range(20, 1));
      @(negedge clock);
    end
    start = 1'b0;
    chk("hold_a_done", 64'(done_a), 64'(1));
    chk("hold_a_cycle_count", 64'(cycle_count_a), 64'(la));
    chk("hold_b_done", 64'(done_b), 64'(1));
    chk("hold_b_cycle_count", 64'(cycle_count_b), 64'(lb));
  endtask

  // Reset lands on the third RUN cycle of a 12-cycle (A) / 4-cycle (B) sequence.
  task automatic abort_seq();
    start   = 1'b1;
    run_len = 16'd12;
    zero_in = 4'hF;
    @(negedge clock);
    start = 1'b0;
    repeat (R + 2) @(negedge clock);
    chk("abort_pre_a_cycle", 64'(cycle_count_a), 64'(2));
    chk("abort_pre_a_run", 64'(core_run_a), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("abort");
    repeat (15) @(negedge clock);
    chk("abort_no_done_a", 64'(done_a), 64'(0));
    chk("abort_no_done_b", 64'(done_b), 64'(0));
  endtask

  task automatic start_with_reset();
    start   = 1'b1;
    reset   = 1'b1;
    run_len = 16'd3;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    check_idle("start_reset");
    repeat (4) @(negedge clock);
    chk("start_reset_stays_idle_a", 64'(busy_a), 64'(0));
    chk("start_reset_stays_idle_b", 64'(busy_b), 64'(0));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    run_len = 16'd0;
    zero_in = 4'd0;
    @(negedge clock);
    check_idle("reset");
    @(negedge clock);
    reset = 1'b0;
    run_seq(16'd0, 1'b1, 4'b0000, 1'b0);
    run_seq(16'd0, 1'b1, 4'b1111, 1'b0);
    run_seq(16'd5, 1'b1, 4'b1111, 1'b0);
    run_seq(16'd10, 1'b1, 4'b0101, 1'b0);
    run_seq(16'd9, 1'b0, 4'b0000, 1'b1);
    abort_seq();
    run_seq(16'd6, 1'b0, 4'b0000, 1'b1);
    start_with_reset();
    for (int k = 0; k < 25; k++) begin
      run_seq(16'($urandom_range(20, 0)), ($urandom_range(3, 0) == 0), 4'($urandom),
              1'($urandom_range(1, 0)));
    end
    repeat (3) @(negedge clock);
    chk("a_pending_expected", 64'(exp_a.size()), 64'(0));
    chk("b_pending_expected", 64'(exp_b.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
